axi_fifo_wr_arb: RTL

AXI_FIFO_WR_ARB -- requirements
Module: axi_fifo_wr_arb

---
 rtl/axi_fifo_wr_arb.sv | 121 ++++++++++++
 1 files changed

// File: rtl/axi_fifo_wr_arb.sv
// rtl/axi_fifo_wr_arb.sv - round-robin burst arbiter feeding a sync FIFO write port
// Grants one requester at a time and passes its beats straight through until last or MAXLEN.
module axi_fifo_wr_arb #(
  parameter int DW     = 42,
  parameter int NREQ   = 4,
  parameter int IW     = 2,
  parameter int MAXLEN = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_vld,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_rdy,
  output logic               fifo_wr_vld,
  output logic [IW+DW-1:0]   fifo_wr_din,
  input  logic               fifo_wr_rdy,
  output logic [IW-1:0]      grant_id,
  output logic               busy
);

  localparam int CW = $clog2(MAXLEN) + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          found;
  logic [IW-1:0] winner;
  logic          g_vld;
  logic          g_last;
  logic [DW-1:0] g_data;
  logic          xfer;
  logic [CW-1:0] cnt_inc;

  // Round-robin search: first requester at offset 1..NREQ from the last grant wins.
  always_comb begin
    found  = 1'b0;
    winner = last_grant_q;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_vld[i] && (i == (int'(last_grant_q) + k) % NREQ)) begin
          found  = 1'b1;
          winner = IW'(i);
        end
      end
    end
  end

  always_comb begin
    g_vld  = 1'b0;
    g_last = 1'b0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == IW'(i)) begin
        g_vld  = req_vld[i];
        g_last = req_last[i];
        g_data = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rdy[i] = (state_q == LOCK) && (grant_id_q == IW'(i)) && fifo_wr_rdy;
    end
  end

  assign fifo_wr_vld = (state_q == LOCK) && g_vld;
  assign fifo_wr_din = {grant_id_q, g_data};
  assign grant_id    = grant_id_q;
  assign busy        = (state_q == LOCK);
  assign xfer        = fifo_wr_vld && fifo_wr_rdy;
  assign cnt_inc     = cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d = winner;
          cnt_d      = '0;
          state_d    = LOCK;
        end
      end
      LOCK: begin
        // A dropped req_vld just stalls; only a completed beat can end the burst.
        if (xfer) begin
          cnt_d = cnt_inc;
          if (g_last || (cnt_inc == CW'(MAXLEN))) begin
            state_d      = IDLE;
            last_grant_d = grant_id_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_id_q   <= IW'(NREQ - 1);
      last_grant_q <= IW'(NREQ - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule
